// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_M    = 2'd1,
    FWD_W    = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // A writer hits a source only when it really writes and the target is not $0.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst,
                                   input logic we);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  // Newest stage wins: M before W.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] src,
                                       input logic regw_m, input logic [4:0] rd_m,
                                       input logic regw_w, input logic [4:0] rd_w);
    if (reg_hit(src, rd_m, regw_m))      return FWD_M;
    else if (reg_hit(src, rd_w, regw_w)) return FWD_W;
    else                                 return FWD_NONE;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0] rsD, rtD;
  logic       use_rsD, use_rtD;
  logic [4:0] rsE, rtE, rdE;
  logic       regwE, memtoregE;
  logic [4:0] rdM;
  logic       regwM, memtoregM;
  logic [4:0] rdW;
  logic       regwW;
  logic       i_wait, d_wait;
  logic       md_startE, md_divE;
  logic       hilo_rdD;

  logic       stallF, stallD, stallE, stallM;
  logic       flushE, flushM;
  pipe_ctrl_pkg::fwd_sel_t fwdaD, fwdbD, fwdaE, fwdbE;
  logic       md_busy, md_done;

  modport master (
    output rsD, rtD, use_rsD, use_rtD, rsE, rtE, rdE, regwE, memtoregE,
           rdM, regwM, memtoregM, rdW, regwW, i_wait, d_wait,
           md_startE, md_divE, hilo_rdD,
    input  stallF, stallD, stallE, stallM, flushE, flushM,
           fwdaD, fwdbD, fwdaE, fwdbE, md_busy, md_done
  );

  modport slave (
    input  rsD, rtD, use_rsD, use_rtD, rsE, rtE, rdE, regwE, memtoregE,
           rdM, regwM, memtoregM, rdW, regwW, i_wait, d_wait,
           md_startE, md_divE, hilo_rdD,
    output stallF, stallD, stallE, stallM, flushE, flushM,
           fwdaD, fwdbD, fwdaE, fwdbE, md_busy, md_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl_muldiv_seq.sv
// Mul/div occupancy sequencer.
//   state | meaning
//   IDLE  | unit free, waiting for an unstalled MULT/DIV in execute
//   BUSY  | operation running, r_cnt counts remaining cycles down to 0
//   DONE  | HI/LO valid this cycle (md_done pulse), unit still reported busy
module muldiv_seq #(
  parameter int MUL_LAT = pipe_ctrl_pkg::MUL_LAT_DEF,
  parameter int DIV_LAT = pipe_ctrl_pkg::DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_startE,
  input  logic md_divE,
  input  logic stallE,
  output logic md_busy,
  output logic md_done
);
  import pipe_ctrl_pkg::*;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  fsm_t          r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          w_accept;
  logic [CW-1:0] w_load;

  // The counter keeps running through bus-wait freezes; only the start is gated by stallE.
  assign w_accept = md_startE && !stallE;
  assign w_load   = md_divE ? DIV_LOAD : MUL_LOAD;
  assign md_busy  = r_busy;
  assign md_done  = r_done;

  // Occupancy FSM with registered busy/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= BUSY;
            r_cnt   <= w_load;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= BUSY;
            r_cnt   <= w_load;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: forwarding selects, stall/flush
// priority and the mul/div sequencer. Optional stall counter: PIPE_HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = pipe_ctrl_pkg::MUL_LAT_DEF,
  parameter int DIV_LAT = pipe_ctrl_pkg::DIV_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);
  import pipe_ctrl_pkg::*;

  logic w_bus_wait, w_md_conflict, w_load_use, w_dec_use, w_hilo_wait;
  logic w_stallF, w_stallD, w_stallE, w_stallM, w_flushE, w_flushM;
  logic w_md_busy, w_md_done;

  assign hz.fwdaE = fwd_sel(hz.rsE, hz.regwM, hz.rdM, hz.regwW, hz.rdW);
  assign hz.fwdbE = fwd_sel(hz.rtE, hz.regwM, hz.rdM, hz.regwW, hz.rdW);
  assign hz.fwdaD = fwd_sel(hz.rsD, hz.regwM, hz.rdM, hz.regwW, hz.rdW);
  assign hz.fwdbD = fwd_sel(hz.rtD, hz.regwM, hz.rdM, hz.regwW, hz.rdW);

  assign w_bus_wait    = hz.i_wait | hz.d_wait;
  assign w_md_conflict = hz.md_startE && w_md_busy;
  assign w_load_use    = hz.memtoregE &&
                         (reg_hit(hz.rsD, hz.rdE, hz.regwE) || reg_hit(hz.rtD, hz.rdE, hz.regwE));
  // Decode-stage readers cannot take an E result at all, nor a load still in M.
  assign w_dec_use     = (hz.use_rsD && (reg_hit(hz.rsD, hz.rdE, hz.regwE) ||
                                         reg_hit(hz.rsD, hz.rdM, hz.memtoregM))) ||
                         (hz.use_rtD && (reg_hit(hz.rtD, hz.rdE, hz.regwE) ||
                                         reg_hit(hz.rtD, hz.rdM, hz.memtoregM)));
  assign w_hilo_wait   = hz.hilo_rdD && (w_md_busy || hz.md_startE);

  // Stall/flush priority; each branch flushes only the stage just below the stalled ones.
  always_comb begin
    w_stallF = 1'b0;
    w_stallD = 1'b0;
    w_stallE = 1'b0;
    w_stallM = 1'b0;
    w_flushE = 1'b0;
    w_flushM = 1'b0;
    if (w_bus_wait) begin
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_stallE = 1'b1;
      w_stallM = 1'b1;
    end else if (w_md_conflict) begin
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_stallE = 1'b1;
      w_flushM = 1'b1;
    end else if (w_load_use || w_dec_use || w_hilo_wait) begin
      w_stallF = 1'b1;
      w_stallD = 1'b1;
      w_flushE = 1'b1;
    end
  end

  assign hz.stallF  = w_stallF;
  assign hz.stallD  = w_stallD;
  assign hz.stallE  = w_stallE;
  assign hz.stallM  = w_stallM;
  assign hz.flushE  = w_flushE;
  assign hz.flushM  = w_flushM;
  assign hz.md_busy = w_md_busy;
  assign hz.md_done = w_md_done;

  muldiv_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_muldiv_seq (
    .clk       (clk),
    .reset     (reset),
    .md_startE (hz.md_startE),
    .md_divE   (hz.md_divE),
    .stallE    (w_stallE),
    .md_busy   (w_md_busy),
    .md_done   (w_md_done)
  );

`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count decode-stall cycles; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_stall_cnt <= 32'd0;
    else if (w_stallD) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [5:0] ST_NONE = 6'b000000; // {sF,sD,sE,sM,fE,fM}
  localparam logic [5:0] ST_DEC  = 6'b110010;
  localparam logic [5:0] ST_MD   = 6'b111001;
  localparam logic [5:0] ST_BUS  = 6'b111100;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } sb_t;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if hz();
`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int unsigned exp_cnt;
`endif

  sb_t sb_q[$];
  int  md_q[$];
  int  n_chk;
  int  n_err;
  int  cyc;
  int  md_s;
  int  md_lat;

  pipe_hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .hz        (hz.slave)
`ifdef PIPE_HAZARD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] mk(input logic [5:0] st, input fwd_sel_t faD,
                                      input fwd_sel_t fbD, input fwd_sel_t faE,
                                      input fwd_sel_t fbE);
    return {st, faD, fbD, faE, fbE};
  endfunction

  task automatic clr();
    hz.rsD = 0; hz.rtD = 0; hz.use_rsD = 0; hz.use_rtD = 0;
    hz.rsE = 0; hz.rtE = 0; hz.rdE = 0; hz.regwE = 0; hz.memtoregE = 0;
    hz.rdM = 0; hz.regwM = 0; hz.memtoregM = 0;
    hz.rdW = 0; hz.regwW = 0;
    hz.i_wait = 0; hz.d_wait = 0;
    hz.md_startE = 0; hz.md_divE = 0; hz.hilo_rdD = 0;
  endtask

  // Called at posedge+1 with stimulus applied; samples mid-cycle, then advances one cycle.
  task automatic step(input string tag, input logic [13:0] ctl);
    sb_t         e;
    logic        mb, md;
    logic [15:0] got;
    mb = (md_s >= 0) && (cyc > md_s) && (cyc <= md_s + md_lat + 1);
    md = (md_s >= 0) && (cyc == md_s + md_lat + 1);
    e.tag = tag;
    e.val = {ctl, mb, md};
    sb_q.push_back(e);
    #3;
    got = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushE, hz.flushM,
           hz.fwdaD, hz.fwdbD, hz.fwdaE, hz.fwdbE, hz.md_busy, hz.md_done};
    e = sb_q.pop_front();
    check(e.tag, 32'(got), 32'(e.val));
    if (hz.md_done === 1'b1) begin
      if (md_q.size() == 0) check("md_done_spurious", 32'd1, 32'd0);
      else                  check("md_done_cycle", cyc, md_q.pop_front());
    end
`ifdef PIPE_HAZARD_STALL_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, exp_cnt);
    if (reset)        exp_cnt = 0;
    else if (ctl[12]) exp_cnt++;
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; md_s = -1; md_lat = 0;
`ifdef PIPE_HAZARD_STALL_CNT_EN
    exp_cnt = 0;
`endif
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step("reset", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    reset = 1'b0;

    // forwarding
    hz.regwM = 1; hz.rdM = 5; hz.regwW = 1; hz.rdW = 5; hz.rsE = 5; hz.rsD = 5;
    step("fwd_m_wins", mk(ST_NONE, FWD_M, FWD_NONE, FWD_M, FWD_NONE));
    clr(); hz.regwM = 1; hz.rdM = 6; hz.regwW = 1; hz.rdW = 5; hz.rtE = 5; hz.rtD = 5;
    step("fwd_w", mk(ST_NONE, FWD_NONE, FWD_W, FWD_NONE, FWD_W));
    clr(); hz.regwM = 1; hz.regwW = 1;
    step("fwd_r0", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));

    // load-use
    clr(); hz.memtoregE = 1; hz.regwE = 1; hz.rdE = 8; hz.rsD = 8;
    step("load_use_rs", mk(ST_DEC, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr();
    step("load_use_release", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    hz.memtoregE = 1; hz.regwE = 1; hz.rdE = 9; hz.rtD = 9;
    step("load_use_rt", mk(ST_DEC, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr(); hz.memtoregE = 1; hz.regwE = 1;
    step("load_use_r0", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));

    // branch operand from E, then from M (ALU result)
    clr(); hz.use_rsD = 1; hz.rsD = 3; hz.regwE = 1; hz.rdE = 3;
    step("br_stall", mk(ST_DEC, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    hz.regwE = 0; hz.rdE = 0; hz.regwM = 1; hz.rdM = 3;
    step("br_fwd", mk(ST_NONE, FWD_M, FWD_NONE, FWD_NONE, FWD_NONE));
    clr(); hz.rsD = 3; hz.regwE = 1; hz.rdE = 3;
    step("no_use_no_stall", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr(); hz.use_rtD = 1; hz.rtD = 4; hz.regwM = 1; hz.memtoregM = 1; hz.rdM = 4;
    step("dec_use_loadM", mk(ST_DEC, FWD_NONE, FWD_M, FWD_NONE, FWD_NONE));

    // bus wait beats load-use
    clr(); hz.d_wait = 1; hz.memtoregE = 1; hz.regwE = 1; hz.rdE = 8; hz.rsD = 8;
    step("dwait_load_use", mk(ST_BUS, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr(); hz.i_wait = 1;
    step("iwait", mk(ST_BUS, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));

    // divide
    clr(); hz.md_startE = 1; hz.md_divE = 1;
    md_s = cyc; md_lat = 32; md_q.push_back(cyc + 33);
    step("div_start", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr();
    step("div_busy", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    hz.hilo_rdD = 1;
    step("hilo_stall", mk(ST_DEC, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr(); hz.md_startE = 1;
    step("md_start_busy", mk(ST_MD, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr(); hz.d_wait = 1;
    step("dwait_div", mk(ST_BUS, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr();
    while (cyc <= md_s + 35)
      step("div_run", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));

    // multiply started alongside a hilo read
    hz.md_startE = 1; hz.hilo_rdD = 1;
    md_s = cyc; md_lat = 4; md_q.push_back(cyc + 5);
    step("hilo_mul_start", mk(ST_DEC, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr();
    while (cyc <= md_s + 7)
      step("mul_run", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));

    // reset in the middle of a divide
    hz.md_startE = 1; hz.md_divE = 1;
    md_s = cyc; md_lat = 32; md_q.push_back(cyc + 33);
    step("div2_start", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    clr();
    repeat (9) step("div2_pre_rst", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    reset = 1'b1;
    #1;
    check("rst_md_busy", 32'(hz.md_busy), 32'd0);
    check("rst_md_done", 32'(hz.md_done), 32'd0);
`ifdef PIPE_HAZARD_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
    exp_cnt = 0;
`endif
    md_s = -1;
    md_q.delete();
    step("in_reset", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));
    reset = 1'b0;
    repeat (40) step("post_rst", mk(ST_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE));

    check("md_done_missing", md_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
